// File: rtl/host_avg_seq_pkg.sv
// Shared types and constants for the host_averager read sequencer.
package host_avg_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      STROBE  = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      SEND    = 3'd4
   } state_t;

   localparam int unsigned WORD_W  = 32;
   localparam logic [7:0]  OVR_MAX = 8'd255;

endpackage

// File: rtl/host_avg_seq_timer.sv
// Free-running auto-read interval timer: expire pulses once every period cycles.
module host_avg_seq_timer #(
   parameter int PW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [PW-1:0] period,
   output logic          expire
);

   localparam logic [PW-1:0] ONE = PW'(1);

   logic [PW-1:0] cnt;
   logic          run;

   // A zero period stops at once; a new nonzero period is only picked up on reload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (period == '0) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (!run || cnt == '0) begin
         cnt <= period - ONE;
         run <= 1'b1;
      end else begin
         cnt <= cnt - ONE;
      end
   end

   assign expire = run && (cnt == '0) && (period != '0);

endmodule

// File: rtl/host_avg_sequencer.sv
// Periodic/manual snapshot of NCH host_averager channels, streamed out one word per beat.
// Optional frame tag counter enabled by defining HOST_AVG_SEQ_TAG_EN.
module host_avg_sequencer #(
   parameter int NCH = 4,
   parameter int PW  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PW-1:0]     period,
   input  logic              host_trig,
   output logic              read_s,
   input  logic [NCH*32-1:0] avg_data,
   output logic [31:0]       out_data,
   output logic [3:0]        out_chan,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [7:0]        overrun,
   output logic [7:0]        out_tag,
   output logic              busy
);

   import host_avg_seq_pkg::*;

   localparam logic [3:0] LAST_CHAN = 4'(NCH - 1);

   state_t            state;
   logic [3:0]        chan;
   logic [WORD_W-1:0] snap [NCH];
   logic              expire;
   logic              trig;

   host_avg_seq_timer #(.PW(PW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .period (period),
      .expire (expire)
   );

   assign trig = host_trig | expire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         chan  <= '0;
      end else begin
         case (state)
            IDLE:    if (trig) state <= STROBE;
            STROBE:  state <= WAIT;
            WAIT:    state <= CAPTURE;
            CAPTURE: begin
               state <= SEND;
               chan  <= '0;
            end
            SEND: begin
               if (out_ready) begin
                  if (chan == LAST_CHAN) begin
                     state <= IDLE;
                     chan  <= '0;
                  end else begin
                     chan <= chan + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Triggers are never queued: anything arriving mid-frame is only counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= '0;
      end else if (trig && state != IDLE && overrun != OVR_MAX) begin
         overrun <= overrun + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NCH; i++) snap[i] <= '0;
      end else if (state == CAPTURE) begin
         for (int unsigned i = 0; i < NCH; i++) snap[i] <= avg_data[i*WORD_W +: WORD_W];
      end
   end

   always_comb begin
      out_data = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (chan == 4'(i)) out_data = snap[i];
      end
   end

   assign read_s    = (state == STROBE);
   assign out_valid = (state == SEND);
   assign out_last  = out_valid && (chan == LAST_CHAN);
   assign out_chan  = chan;
   assign busy      = (state != IDLE);

`ifdef HOST_AVG_SEQ_TAG_EN
   logic [7:0] tag_cnt;
   logic [7:0] tag_q;

   // tag_q carries the number of the frame being streamed; tag_cnt is the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_cnt <= '0;
         tag_q   <= '0;
      end else if (state == CAPTURE) begin
         tag_q   <= tag_cnt;
         tag_cnt <= tag_cnt + 8'd1;
      end
   end

   assign out_tag = tag_q;
`else
   assign out_tag = '0;
`endif

endmodule

// File: tb/tb_host_avg_sequencer.sv
// Scoreboard bench for host_avg_sequencer (NCH=4, PW=16); honours HOST_AVG_SEQ_TAG_EN.
module tb_host_avg_sequencer;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  c;
      logic        l;
      logic [7:0]  t;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [15:0]  period = '0;
   logic         host_trig = 1'b0;
   logic         read_s;
   logic [127:0] avg_data = '0;
   logic [31:0]  out_data;
   logic [3:0]   out_chan;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic         out_last;
   logic [7:0]   overrun;
   logic [7:0]   out_tag;
   logic         busy;

   int    total = 0;
   int    bad   = 0;
   int    frame_no = 0;
   beat_t sbq [$];
   beat_t held;
   logic  held_v = 1'b0;
   logic  prev_rs = 1'b0;

   localparam logic [127:0] W_A = {32'h44444104, 32'h33333103, 32'h22222102, 32'h11111101};
   localparam logic [127:0] W_B = {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};

   host_avg_sequencer #(.NCH(4), .PW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .period    (period),
      .host_trig (host_trig),
      .read_s    (read_s),
      .avg_data  (avg_data),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .overrun   (overrun),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [127:0] words);
      beat_t b;
      for (int c = 0; c < 4; c++) begin
         b.d = words[c*32 +: 32];
         b.c = 4'(c);
         b.l = (c == 3);
`ifdef HOST_AVG_SEQ_TAG_EN
         b.t = 8'(frame_no);
`else
         b.t = 8'd0;
`endif
         sbq.push_back(b);
      end
      frame_no++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic trigger();
      step();
      host_trig = 1'b1;
      step();
      host_trig = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         step();
         if (!busy && sbq.size() == 0) done = 1;
      end
      if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_valid(input string name);
      bit done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         step();
         if (out_valid) done = 1;
      end
      if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sbq.delete();
      frame_no = 0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Monitor: pops one expected beat per accepted handshake and checks stall stability.
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         held_v  = 1'b0;
         prev_rs = 1'b0;
      end else begin
         if (read_s) chk("read_s_gap", {31'd0, prev_rs}, 32'd0);
         prev_rs = read_s;
         if (held_v) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", out_data, held.d);
            chk("hold_chan", {28'd0, out_chan}, {28'd0, held.c});
            chk("hold_last", {31'd0, out_last}, {31'd0, held.l});
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               chk("unexpected_beat_chan", {28'd0, out_chan}, 32'hFFFFFFFF);
            end else begin
               e = sbq.pop_front();
               chk("beat_data", out_data, e.d);
               chk("beat_chan", {28'd0, out_chan}, {28'd0, e.c});
               chk("beat_last", {31'd0, out_last}, {31'd0, e.l});
               chk("beat_tag", {24'd0, out_tag}, {24'd0, e.t});
            end
         end
         held_v = out_valid && !out_ready;
         held.d = out_data;
         held.c = out_chan;
         held.l = out_last;
      end
   end

   initial begin
      int last_cyc;
      int cyc;
      int pulses;

      avg_data = W_A;
      step();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_read_s", {31'd0, read_s}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_overrun", {24'd0, overrun}, 32'd0);
      chk("rst_tag", {24'd0, out_tag}, 32'd0);
      chk("rst_chan", {28'd0, out_chan}, 32'd0);
      step();
      rst = 1'b0;
      step();

      // Manual trigger: strobe one cycle after the trigger edge, then four beats.
      push_frame(W_A);
      host_trig = 1'b1;
      chk("t1_read_s_pre", {31'd0, read_s}, 32'd0);
      step();
      host_trig = 1'b0;
      chk("t1_read_s", {31'd0, read_s}, 32'd1);
      step();
      chk("t1_read_s_off", {31'd0, read_s}, 32'd0);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      wait_idle("t1");
      chk("t1_idle_valid", {31'd0, out_valid}, 32'd0);

      // Timer-driven reads every 100 cycles.
      for (int f = 0; f < 11; f++) push_frame(W_A);
      period = 16'd100;
      cyc = 0;
      pulses = 0;
      last_cyc = 0;
      for (int i = 0; i < 1400 && pulses < 11; i++) begin
         step();
         cyc++;
         if (read_s) begin
            if (pulses > 0) chk("t2_interval", 32'(cyc - last_cyc), 32'd100);
            last_cyc = cyc;
            pulses++;
         end
      end
      period = 16'd0;
      chk("t2_pulses", 32'(pulses), 32'd11);
      wait_idle("t2");
      chk("t2_overrun", {24'd0, overrun}, 32'd0);

      // Stall in SEND for 50 cycles with three dropped triggers and changing inputs.
      out_ready = 1'b0;
      push_frame(W_A);
      trigger();
      wait_valid("t3");
      avg_data = W_B;
      for (int k = 0; k < 50; k++) begin
         host_trig = (k == 10 || k == 20 || k == 30);
         step();
      end
      host_trig = 1'b0;
      chk("t3_overrun", {24'd0, overrun}, 32'd3);
      chk("t3_chan", {28'd0, out_chan}, 32'd0);
      chk("t3_data", out_data, 32'h11111101);
      out_ready = 1'b1;
      wait_idle("t3");

      // Saturation of the overrun counter.
      out_ready = 1'b0;
      push_frame(W_B);
      trigger();
      wait_valid("t5");
      host_trig = 1'b1;
      for (int k = 0; k < 300; k++) step();
      host_trig = 1'b0;
      chk("t5_overrun", {24'd0, overrun}, 32'd255);
      out_ready = 1'b1;
      wait_idle("t5");
      chk("t5_overrun_hold", {24'd0, overrun}, 32'd255);

      // Reset in the middle of the chan 1 beat aborts the frame.
      avg_data = W_A;
      push_frame(W_A);
      trigger();
      begin
         bit found = 0;
         for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (out_valid && out_chan == 4'd1) found = 1;
         end
         if (!found) chk("t4_chan1_timeout", 32'd0, 32'd1);
      end
      rst = 1'b1;
      sbq.delete();
      frame_no = 0;
      #1;
      chk("t4_valid", {31'd0, out_valid}, 32'd0);
      chk("t4_busy", {31'd0, busy}, 32'd0);
      chk("t4_overrun", {24'd0, overrun}, 32'd0);
      step();
      step();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) step();
      chk("t4_quiet", {31'd0, out_valid | busy}, 32'd0);
      push_frame(W_A);
      trigger();
      wait_idle("t4");

      // 257 frames to check tag sequence and wrap.
      do_reset();
      avg_data = W_B;
      for (int f = 0; f < 257; f++) begin
         push_frame(W_B);
         trigger();
         wait_idle("t6");
      end
`ifdef HOST_AVG_SEQ_TAG_EN
      chk("t6_tag_final", {24'd0, out_tag}, 32'd0);
`else
      chk("t6_tag_zero", {24'd0, out_tag}, 32'd0);
`endif
      chk("t6_overrun", {24'd0, overrun}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
